approx_mult_pipe: RTL and testbench
===================================

// Module: approx_mult_pipe
// PURPOSE
//  Parametrised, pipelined N x N unsigned approximate multiplier built from 4x4 tiles.
//  Two approximation knobs are selectable per transaction:
//   - truncated low-weight tiles;
//   - OR-combined low result bits.
//  Sits between operand producers and consumers via valid/ready streams.
//  Counts completed transactions for error-characterisation benches.
// PARAMETERS
//  N          8  operand width; multiple of 4, range 4..32
//  TRUNC      2  low bits zeroed in each truncated tile product (0..7)
//  TRUNC_TILES 1 tile (i,j) is truncated when i+j < TRUNC_TILES (i: A nibble, j: B nibble)
//  ORC_BITS   8  low result bits formed by OR instead of add (0..2N; 0 = exact combine)
//  CNT_W      16 width of transaction counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands/mode valid
//  in_ready   out  1      block can accept operands
//  in_a       in   N      multiplicand, unsigned
//  in_b       in   N      multiplier, unsigned
//  in_mode    in   2      bit0: tile truncation enable; bit1: OR-combine enable
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_r      out  2N     product
//  out_mode   out  2      mode the result was computed with
//  out_cnt    out  CNT_W  number of results handed off (out_valid & out_ready)
// BEHAVIOUR
//  Reset
//   - Clocking: one clock, clk. Reset rst_n is asynchronous, active-low.
//   - All valids 0; out_r 0; out_mode 0; out_cnt 0.
//   - Reset mid-operation discards all in-flight transactions. No output follows.
//  Handshakes
//   - Accept on in_valid & in_ready.
//   - Hand-off on out_valid & out_ready.
//   - out_r and out_mode are held stable while out_valid & !out_ready.
//  Pipeline: 2 register stages, latency 2 cycles from accept to out_valid when unstalled.
//   - S1 registers all (N/4)^2 tile products plus valid and mode.
//   - S2 registers the combined result plus valid and mode.
//   - Stall: stall = out_valid & !out_ready. A stall freezes S1 and S2.
//   - in_ready = !stall; it is combinational from out_ready.
//   - Throughput is 1 result per cycle with no bubbles when out_ready stays 1.
//   - Bubbles advance: an empty S1 still shifts into S2 when there is no stall.
//  Tiles
//   - p(i,j) = A[4i+3:4i] * B[4j+3:4j], exact 8-bit.
//   - If mode[0] and i+j < TRUNC_TILES: p(i,j) &= ~((1<<TRUNC)-1).
//   - Aligned product q(i,j) = p(i,j) << 4(i+j), 2N-bit.
//  Combine (S2)
//   - mode[1]=0: R = sum of all q(i,j), mod 2^2N (exact add).
//   - mode[1]=1, L = ORC_BITS:
//     - R[L-1:0] = bitwise OR of q(i,j)[L-1:0].
//     - R[2N-1:L] = sum of q(i,j)[2N-1:L], mod 2^(2N-L).
//     - Carries out of the low region are dropped.
//   - L=0: mode[1] has no effect. L=2N: R = OR of all q.
//  Mode travels with its operands. Back-to-back transactions with different modes are independent.
//  Counter: out_cnt increments on each hand-off and wraps at 2^CNT_W to 0.
//  Status outputs: no overflow or saturation flags; the product always fits in 2N bits.
// TESTING (N=8, defaults)
//  1. A=FF, B=FF, mode 00 -> out_r=FE01 two cycles after accept; out_cnt 0->1.
//  2. A=FF, B=FF, mode 01 -> FE00 (tile00 E1->E0). Mode 10 -> FDF1. Mode 11 -> FDF0.
//  3. Stream A=1..20, B=3, mode 00, out_ready=1 -> one result/cycle, R=3A, in_ready never 0.
//  4. out_ready=0 for 5 cycles with 3 ops in flight -> in_ready=0; out_r/out_mode stable.
//     Then release -> all 3 results delivered in order, none lost or duplicated.
//  5. Alternate modes 00/11 on A=FF, B=FF back-to-back -> FE01, FDF0, FE01, FDF0.
//  6. Assert rst_n low with S1 and S2 full -> out_valid=0, out_r=0, out_cnt=0 immediately.
//     No stale result after release. Separately, force out_cnt to FFFF and hand off -> 0000.

Source files
------------

// File: rtl/approx_mult_pipe.sv
// Two-stage pipelined N x N unsigned approximate multiplier built from 4x4 tiles.
// Per-transaction knobs: truncated low-weight tiles (mode[0]) and an OR-combined low region (mode[1]).
module approx_mult_pipe #(
  parameter int unsigned N           = 8,
  parameter int unsigned TRUNC       = 2,
  parameter int unsigned TRUNC_TILES = 1,
  parameter int unsigned ORC_BITS    = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_r,
  output logic [1:0]       out_mode,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int unsigned T  = N / 4;
  localparam int unsigned NT = T * T;
  localparam int unsigned W  = 2 * N;
  localparam logic [7:0]   TRUNC_MASK = ~8'((1 << TRUNC) - 1);
  localparam logic [W-1:0] LOW_MASK   = (ORC_BITS == 0) ? '0 : ({W{1'b1}} >> (W - ORC_BITS));

  logic             w_stall;
  logic [7:0]       w_tile [NT];
  logic [W-1:0]     w_q    [NT];
  logic [W-1:0]     w_sum;
  logic [W-1:0]     w_or;
  logic [W-1:0]     w_comb;

  logic             r_s1_valid;
  logic [1:0]       r_s1_mode;
  logic [7:0]       r_s1_prod [NT];
  logic             r_s2_valid;
  logic [1:0]       r_s2_mode;
  logic [W-1:0]     r_s2_r;
  logic [CNT_W-1:0] r_cnt;

  // A stalled output freezes both stages; in_ready is the only combinational output.
  assign w_stall  = r_s2_valid & ~out_ready;
  assign in_ready = ~w_stall;

  // Tile products (optionally truncated) and their weight-aligned versions
  for (genvar gi = 0; gi < T; gi++) begin : g_a
    for (genvar gj = 0; gj < T; gj++) begin : g_b
      logic [7:0] w_p;
      assign w_p = 8'(in_a[4*gi +: 4]) * 8'(in_b[4*gj +: 4]);
      assign w_tile[gi*T+gj] = (in_mode[0] && (gi + gj) < TRUNC_TILES) ? (w_p & TRUNC_MASK) : w_p;
      assign w_q[gi*T+gj] = W'(r_s1_prod[gi*T+gj]) << (4 * (gi + gj));
    end
  end

  // OR-combine masks each tile into disjoint regions, so carries out of the low region vanish
  always_comb begin
    w_sum = '0;
    w_or  = '0;
    for (int unsigned k = 0; k < NT; k++) begin
      if (r_s1_mode[1]) begin
        w_or  = w_or | (w_q[k] & LOW_MASK);
        w_sum = w_sum + (w_q[k] & ~LOW_MASK);
      end else begin
        w_sum = w_sum + w_q[k];
      end
    end
    w_comb = w_sum | w_or;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 2'b00;
      for (int unsigned k = 0; k < NT; k++) r_s1_prod[k] <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_mode <= in_mode;
        for (int unsigned k = 0; k < NT; k++) r_s1_prod[k] <= w_tile[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_mode  <= 2'b00;
      r_s2_r     <= '0;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_mode <= r_s1_mode;
        r_s2_r    <= w_comb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_s2_valid && out_ready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_s2_valid;
  assign out_mode  = r_s2_mode;
  assign out_r     = r_s2_r;
  assign out_cnt   = r_cnt;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Bench for approx_mult_pipe (N=8 defaults): arithmetic reference model plus a narrow-counter
// second instance so counter wrap is reached within a short run.
module tb_approx_mult_pipe;

  localparam int N = 8, TRUNC = 2, TRUNC_TILES = 1, ORC_BITS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_a, in_b;
  logic [1:0]  in_mode, out_mode;
  logic [15:0] out_r, out_cnt;
  logic        s_in_ready, s_out_valid;
  logic [1:0]  s_out_mode;
  logic [15:0] s_out_r;
  logic [3:0]  s_out_cnt;

  int n_chk = 0, n_err = 0, n_hand = 0, cyc_n = 0;
  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];
  int          got_t[$];
  logic [15:0] tbl [4] = '{16'hFE01, 16'hFE00, 16'hFDF1, 16'hFDF0};

  always #5 clk = ~clk;

  approx_mult_pipe #(.N(N), .TRUNC(TRUNC), .TRUNC_TILES(TRUNC_TILES), .ORC_BITS(ORC_BITS), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .out_mode(out_mode), .out_cnt(out_cnt));

  approx_mult_pipe #(.N(N), .TRUNC(TRUNC), .TRUNC_TILES(TRUNC_TILES), .ORC_BITS(ORC_BITS), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .out_valid(s_out_valid), .out_ready(out_ready), .out_r(s_out_r),
    .out_mode(s_out_mode), .out_cnt(s_out_cnt));

  // Reference: nibble products, optional truncation, weight alignment, exact or OR-split combine
  function automatic logic [15:0] model(input int a, input int b, input int m);
    int p, q, ex, lo, hi;
    ex = 0; lo = 0; hi = 0;
    for (int i = 0; i < N / 4; i++)
      for (int j = 0; j < N / 4; j++) begin
        p = ((a >> (4 * i)) % 16) * ((b >> (4 * j)) % 16);
        if ((m % 2) == 1 && (i + j) < TRUNC_TILES) p = p - (p % (1 << TRUNC));
        q = p * (1 << (4 * (i + j)));
        ex = ex + q;
        lo = lo | (q % (1 << ORC_BITS));
        hi = hi + (q >> ORC_BITS);
      end
    if (m >= 2) return 16'(((hi << ORC_BITS) | lo) % 65536);
    return 16'(ex % 65536);
  endfunction

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Scoreboard: inputs and outputs are stable at the falling edge before the capturing edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back({in_mode, model(int'(in_a), int'(in_b), int'(in_mode))});
      if (out_valid && out_ready) begin
        got_q.push_back({out_mode, out_r});
        got_t.push_back(cyc_n);
        n_hand++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = m;
  endtask

  task automatic clear_q();
    got_q.delete(); exp_q.delete(); got_t.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_chk++; if (out_r !== 16'h0) begin n_err++; $display("FAIL reset_r: got %h want 0000", out_r); end
    n_chk++; if (out_mode !== 2'b00) begin n_err++; $display("FAIL reset_mode: got %b want 00", out_mode); end
    n_chk++; if (out_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 0000", out_cnt); end
    n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_modes();
    int c0;
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      c0 = n_hand;
      cyc(); drive(8'hFF, 8'hFF, 2'(m));
      cyc(); idle();
      @(negedge clk);
      n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat1_valid m%0d: got %b want 0", m, out_valid); end
      cyc(); @(negedge clk);
      n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lat2_valid m%0d: got %b want 1", m, out_valid); end
      n_chk++; if (out_r !== tbl[m]) begin n_err++; $display("FAIL mode_r m%0d: got %h want %h", m, out_r, tbl[m]); end
      n_chk++; if (out_mode !== 2'(m)) begin n_err++; $display("FAIL mode_tag m%0d: got %b want %b", m, out_mode, 2'(m)); end
      n_chk++; if (out_cnt !== 16'(c0)) begin n_err++; $display("FAIL cnt_pre m%0d: got %h want %h", m, out_cnt, 16'(c0)); end
      cyc(); @(negedge clk);
      n_chk++; if (out_cnt !== 16'(c0 + 1)) begin n_err++; $display("FAIL cnt_post m%0d: got %h want %h", m, out_cnt, 16'(c0 + 1)); end
    end
  endtask

  task automatic test_stream();
    int ready_low;
    ready_low = 0;
    clear_q();
    out_ready = 1'b1;
    for (int a = 1; a <= 20; a++) begin
      cyc(); drive(8'(a), 8'd3, 2'b00);
      @(negedge clk);
      if (in_ready !== 1'b1) ready_low++;
    end
    cyc(); idle();
    for (int k = 0; k < 10 && got_q.size() < 20; k++) cyc();
    n_chk++; if (ready_low != 0) begin n_err++; $display("FAIL stream_ready: got %0d low cycles want 0", ready_low); end
    n_chk++; if (got_q.size() != 20) begin n_err++; $display("FAIL stream_count: got %0d want 20", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== {2'b00, 16'(3 * (i + 1))}) begin
        n_err++; $display("FAIL stream_r[%0d]: got %h want %h", i, got_q[i], {2'b00, 16'(3 * (i + 1))});
      end
    end
    if (got_q.size() == 20) begin
      n_chk++; if (got_t[19] - got_t[0] != 19) begin n_err++; $display("FAIL stream_gap: got %0d want 19", got_t[19] - got_t[0]); end
    end
    @(negedge clk);
    n_chk++; if (out_cnt !== 16'(n_hand)) begin n_err++; $display("FAIL stream_cnt: got %h want %h", out_cnt, 16'(n_hand)); end
    n_chk++; if (s_out_cnt !== 4'(n_hand % 16)) begin n_err++; $display("FAIL wrap_cnt: got %h want %h", s_out_cnt, 4'(n_hand % 16)); end
  endtask

  task automatic test_stall();
    logic [7:0]  a [3];
    logic [7:0]  b [3];
    logic [1:0]  m [3];
    logic [15:0] hold_r;
    logic [1:0]  hold_m;
    int bad;
    for (int i = 0; i < 3; i++) begin a[i] = 8'($urandom); b[i] = 8'($urandom); m[i] = 2'($urandom); end
    clear_q();
    out_ready = 1'b0;
    cyc(); drive(a[0], b[0], m[0]);
    cyc(); drive(a[1], b[1], m[1]);
    cyc(); drive(a[2], b[2], m[2]);
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: got %b want 0", in_ready); end
    n_chk++; if ({out_mode, out_r} !== {m[0], model(a[0], b[0], m[0])}) begin
      n_err++; $display("FAIL stall_head: got %h want %h", {out_mode, out_r}, {m[0], model(a[0], b[0], m[0])});
    end
    hold_r = out_r; hold_m = out_mode; bad = 0;
    repeat (5) begin
      cyc(); @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_r !== hold_r || out_mode !== hold_m) bad++;
    end
    n_chk++; if (bad != 0) begin n_err++; $display("FAIL stall_hold: got %0d unstable cycles want 0", bad); end
    cyc(); out_ready = 1'b1;
    cyc(); idle();
    for (int k = 0; k < 10 && got_q.size() < 3; k++) cyc();
    repeat (3) cyc();
    n_chk++; if (got_q.size() != 3) begin n_err++; $display("FAIL stall_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== {m[i], model(a[i], b[i], m[i])}) begin
        n_err++; $display("FAIL stall_r[%0d]: got %h want %h", i, got_q[i], {m[i], model(a[i], b[i], m[i])});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ms [4] = '{2'b00, 2'b11, 2'b00, 2'b11};
    clear_q();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin cyc(); drive(8'hFF, 8'hFF, ms[k]); end
    cyc(); idle();
    for (int k = 0; k < 10 && got_q.size() < 4; k++) cyc();
    n_chk++; if (got_q.size() != 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", got_q.size()); end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      n_chk++;
      if (got_q[k] !== {ms[k], tbl[ms[k]]}) begin
        n_err++; $display("FAIL b2b_r[%0d]: got %h want %h", k, got_q[k], {ms[k], tbl[ms[k]]});
      end
    end
    if (got_q.size() == 4) begin
      n_chk++; if (got_t[3] - got_t[0] != 3) begin n_err++; $display("FAIL b2b_gap: got %0d want 3", got_t[3] - got_t[0]); end
    end
  endtask

  task automatic test_random();
    logic took;
    took = 1'b0;
    clear_q();
    idle();
    for (int c = 0; c < 300; c++) begin
      cyc();
      if (!in_valid || took) begin
        in_valid = ($urandom_range(3) != 0);
        in_a = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
        in_b = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
        in_mode = 2'($urandom);
      end
      out_ready = ($urandom_range(9) < 7);
      @(negedge clk);
      took = in_valid && in_ready;
    end
    cyc(); idle(); out_ready = 1'b1;
    for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) cyc();
    n_chk++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_r[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    out_ready = 1'b0;
    cyc(); drive(8'hFF, 8'hFF, 2'b00);
    cyc(); drive(8'h12, 8'h34, 2'b11);
    cyc(); idle();
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_chk++; if (out_r !== 16'h0) begin n_err++; $display("FAIL rst_r: got %h want 0000", out_r); end
    n_chk++; if (out_cnt !== 16'h0) begin n_err++; $display("FAIL rst_cnt: got %h want 0000", out_cnt); end
    n_chk++; if (s_out_cnt !== 4'h0) begin n_err++; $display("FAIL rst_cnt_s: got %h want 0", s_out_cnt); end
    clear_q(); n_hand = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (out_valid !== 1'b0) seen++; end
    n_chk++; if (seen != 0 || got_q.size() != 0) begin n_err++; $display("FAIL rst_stale: got %0d valid cycles want 0", seen); end
    cyc(); drive(8'hFF, 8'hFF, 2'b10);
    cyc(); idle();
    cyc(); @(negedge clk);
    n_chk++; if (out_r !== 16'hFDF1) begin n_err++; $display("FAIL rst_after_r: got %h want FDF1", out_r); end
    cyc(); @(negedge clk);
    n_chk++; if (out_cnt !== 16'h1) begin n_err++; $display("FAIL rst_after_cnt: got %h want 0001", out_cnt); end
  endtask

  initial begin
    idle();
    out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_modes();
    test_stream();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
